// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue.
//  - Branch type codes carried on enq_type_i / ex_branch_type_o.
//  - FSM state codes for the top-level RUN/FLUSH controller.
//  - Queue entry layout and the mispredict / redirect helpers.
// No ports; imported by brq_fifo and branch_resolve_queue.
package branch_resolve_queue_pkg;

    typedef enum logic [1:0] {
        TypeNo     = 2'b00,
        TypeBranch = 2'b01,
        TypeRet    = 2'b10,
        TypeJ      = 2'b11
    } br_type_e;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } state_e;

    // Fall-through PC skips the branch and its delay slot.
    localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

    typedef struct packed {
        logic [31:0] inst_addr;
        br_type_e    br_type;
        logic        pred_taken;
        logic [31:0] pred_target;
    } brq_entry_t;

    // Conditional branches compare direction, and target only when both sides say taken.
    // ret/j are always taken, so only the target matters.
    function automatic logic is_mispredict(brq_entry_t e, logic taken, logic [31:0] target);
        if (e.br_type == TypeBranch) begin
            return (e.pred_taken != taken) || (taken && (e.pred_target != target));
        end
        return e.pred_target != target;
    endfunction

    function automatic logic [31:0] redirect_pc(logic [31:0] addr, logic taken,
                                                logic [31:0] target);
        return taken ? target : addr + DELAY_SLOT_OFFSET;
    endfunction

endpackage

// File: rtl/brq_fifo.sv
// Circular buffer holding outstanding branch predictions in program order.
// Ports:
//  clk, rst    clock / asynchronous active-low reset
//  push        write push_data at tail (caller guarantees not full)
//  push_data   entry to store
//  pop         advance head (caller guarantees not empty)
//  clear       drop every entry; dominates push/pop
//  head_data   oldest entry (combinational read)
//  full/empty  occupancy flags
module brq_fifo
    import branch_resolve_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  brq_entry_t push_data,
    input  logic       pop,
    input  logic       clear,
    output brq_entry_t head_data,
    output logic       full,
    output logic       empty
);

    brq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    // Pointers wrap naturally because DEPTH == 2**PTR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[tail] <= push_data;
    end

    assign head_data = mem[head];
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of front-end branch predictions matched against EX outcomes.
// Emits a one-cycle training stream and, on mispredict, a one-cycle flush with redirect PC.
// Optional feature macro: BRQ_STATS_EN adds stat_resolved_o / stat_mispred_o counters.
// Ports:
//  clk, rst                                   clock / asynchronous active-low reset
//  enq_valid_i/enq_ready_o                    enqueue handshake from inst_buffer
//  enq_inst_addr_i/type_i/pred_taken_i/pred_target_i   prediction being recorded
//  res_valid_i/res_taken_i/res_target_i       EX outcome for the oldest entry
//  ex_branch_type_o/success_o/inst_addr_o     registered training outputs
//  flush_o/redirect_pc_o                      registered mispredict flush and target
//  empty_o                                    no outstanding entries
//  stat_resolved_o/stat_mispred_o             (BRQ_STATS_EN only) event counters
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enq_valid_i,
    output logic        enq_ready_o,
    input  logic [31:0] enq_inst_addr_i,
    input  logic [1:0]  enq_type_i,
    input  logic        enq_pred_taken_i,
    input  logic [31:0] enq_pred_target_i,
    input  logic        res_valid_i,
    input  logic        res_taken_i,
    input  logic [31:0] res_target_i,
    output logic [1:0]  ex_branch_type_o,
    output logic        ex_branch_success_o,
    output logic [31:0] ex_inst_addr_o,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o,
    output logic        empty_o
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0] stat_resolved_o,
    output logic [31:0] stat_mispred_o
`endif
);

    state_e     state;
    brq_entry_t head_entry;
    brq_entry_t enq_entry;
    logic       full;
    logic       empty;
    logic       res_accept;
    logic       mispred;
    logic       push;
    logic       pop;

    assign enq_ready_o = (state == StRun) && !full;
    assign empty_o     = empty;

    // Resolves are ignored while flushing or when nothing is outstanding.
    assign res_accept = res_valid_i && (state == StRun) && !empty;
    assign mispred    = res_accept && is_mispredict(head_entry, res_taken_i, res_target_i);

    // A mispredict wipes the queue, so a same-cycle enqueue is younger-than-branch and dropped.
    assign push = enq_valid_i && enq_ready_o && (br_type_e'(enq_type_i) != TypeNo) && !mispred;
    assign pop  = res_accept && !mispred;

    always_comb begin
        enq_entry             = '0;
        enq_entry.inst_addr   = enq_inst_addr_i;
        enq_entry.br_type     = br_type_e'(enq_type_i);
        enq_entry.pred_taken  = (br_type_e'(enq_type_i) == TypeBranch) ? enq_pred_taken_i : 1'b1;
        enq_entry.pred_target = enq_pred_target_i;
    end

    brq_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (enq_entry),
        .pop       (pop),
        .clear     (mispred),
        .head_data (head_entry),
        .full      (full),
        .empty     (empty)
    );

    // FSM plus registered training / flush outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= StRun;
            ex_branch_type_o    <= TypeNo;
            ex_branch_success_o <= 1'b0;
            ex_inst_addr_o      <= '0;
            flush_o             <= 1'b0;
            redirect_pc_o       <= '0;
        end else begin
            ex_branch_type_o    <= res_accept ? head_entry.br_type : TypeNo;
            ex_branch_success_o <= res_accept && res_taken_i;
            ex_inst_addr_o      <= res_accept ? head_entry.inst_addr : '0;
            flush_o             <= mispred;
            redirect_pc_o       <= mispred ?
                                   redirect_pc(head_entry.inst_addr, res_taken_i, res_target_i) :
                                   '0;
            unique case (state)
                StRun:   if (mispred) state <= StFlush;
                StFlush: state <= StRun;
                default: state <= StRun;
            endcase
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_resolved_o <= '0;
            stat_mispred_o  <= '0;
        end else begin
            if (res_accept) stat_resolved_o <= stat_resolved_o + 32'd1;
            if (mispred)    stat_mispred_o  <= stat_mispred_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point,
// so registered outputs observed after a cycle reflect the inputs of that cycle.
module tb_branch_resolve_queue;

    logic        clk;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_inst_addr;
    logic [1:0]  enq_type;
    logic        enq_pred_taken;
    logic [31:0] enq_pred_target;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic [1:0]  ex_branch_type;
    logic        ex_branch_success;
    logic [31:0] ex_inst_addr;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        empty;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_queue #(
        .DEPTH (8),
        .PTR_W (3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enq_valid_i         (enq_valid),
        .enq_ready_o         (enq_ready),
        .enq_inst_addr_i     (enq_inst_addr),
        .enq_type_i          (enq_type),
        .enq_pred_taken_i    (enq_pred_taken),
        .enq_pred_target_i   (enq_pred_target),
        .res_valid_i         (res_valid),
        .res_taken_i         (res_taken),
        .res_target_i        (res_target),
        .ex_branch_type_o    (ex_branch_type),
        .ex_branch_success_o (ex_branch_success),
        .ex_inst_addr_o      (ex_inst_addr),
        .flush_o             (flush),
        .redirect_pc_o       (redirect_pc),
        .empty_o             (empty)
`ifdef BRQ_STATS_EN
        ,
        .stat_resolved_o     (stat_resolved),
        .stat_mispred_o      (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then land 1 unit past the rising edge.
    task automatic cycle(input logic ev, input logic [31:0] ea, input logic [1:0] et,
                         input logic ept, input logic [31:0] etgt,
                         input logic rv, input logic rt, input logic [31:0] rtgt);
        enq_valid       = ev;
        enq_inst_addr   = ea;
        enq_type        = et;
        enq_pred_taken  = ept;
        enq_pred_target = etgt;
        res_valid       = rv;
        res_taken       = rt;
        res_target      = rtgt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        enq_valid = 1'b0; enq_inst_addr = '0; enq_type = '0; enq_pred_taken = 1'b0;
        enq_pred_target = '0; res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_ready", 32'(enq_ready), 32'd1);
        check_eq("rst_type", 32'(ex_branch_type), 32'd0);
        check_eq("rst_flush", 32'(flush), 32'd0);
        check_eq("rst_redirect", redirect_pc, 32'h0);
        rst = 1'b1;
        idle();

        // Correct taken branch
        cycle(1'b1, 32'h100, 2'b01, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        check_eq("enq_not_empty", 32'(empty), 32'd0);
        cycle(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
        check_eq("ok_type", 32'(ex_branch_type), 32'd1);
        check_eq("ok_success", 32'(ex_branch_success), 32'd1);
        check_eq("ok_addr", ex_inst_addr, 32'h100);
        check_eq("ok_flush", 32'(flush), 32'd0);
        check_eq("ok_empty", 32'(empty), 32'd1);
        idle();
        check_eq("ok_type_back_idle", 32'(ex_branch_type), 32'd0);

        // Direction mispredict with a concurrent (dropped) enqueue
        cycle(1'b1, 32'h100, 2'b01, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'h500, 2'b01, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
        check_eq("mp_flush", 32'(flush), 32'd1);
        check_eq("mp_redirect", redirect_pc, 32'h108);
        check_eq("mp_empty", 32'(empty), 32'd1);
        check_eq("mp_ready_low", 32'(enq_ready), 32'd0);
        check_eq("mp_type", 32'(ex_branch_type), 32'd1);
        check_eq("mp_success", 32'(ex_branch_success), 32'd0);
        // FLUSH cycle: enqueue refused, resolve ignored
        cycle(1'b1, 32'h700, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("fl_flush_drop", 32'(flush), 32'd0);
        check_eq("fl_type_idle", 32'(ex_branch_type), 32'd0);
        check_eq("fl_ready_back", 32'(enq_ready), 32'd1);
        check_eq("fl_still_empty", 32'(empty), 32'd1);

        // Jump target mispredict (pred_taken ignored for j)
        cycle(1'b1, 32'h300, 2'b11, 1'b0, 32'h400, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 32'h480);
        check_eq("j_flush", 32'(flush), 32'd1);
        check_eq("j_redirect", redirect_pc, 32'h480);
        check_eq("j_type", 32'(ex_branch_type), 32'd3);
        check_eq("j_addr", ex_inst_addr, 32'h300);
        idle();
        check_eq("j_flush_pulse", 32'(flush), 32'd0);

        // Type 00 enqueue writes nothing
        cycle(1'b1, 32'h900, 2'b00, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("none_empty", 32'(empty), 32'd1);
        check_eq("none_ready", 32'(enq_ready), 32'd1);

        // Fill to DEPTH with not-taken branches
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'h1000 + 32'(4 * i), 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        check_eq("full_ready_low", 32'(enq_ready), 32'd0);
        // Enqueue while full: dropped
        cycle(1'b1, 32'h1800, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_eq("full_still_low", 32'(enq_ready), 32'd0);
        // Resolve while full: no bypass, enqueue dropped, head popped
        cycle(1'b1, 32'h1900, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("full_res_addr", ex_inst_addr, 32'h1000);
        check_eq("full_res_flush", 32'(flush), 32'd0);
        check_eq("full_res_ready", 32'(enq_ready), 32'd1);
        // Steady resolve+enqueue across pointer wrap: occupancy holds at 7
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'h2000 + 32'(4 * k), 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            check_eq("wrap_addr", ex_inst_addr,
                     (k < 7) ? 32'h1004 + 32'(4 * k) : 32'h2000 + 32'(4 * (k - 7)));
            check_eq("wrap_ready", 32'(enq_ready), 32'd1);
        end
        // Drain remaining 0x200c..0x2024
        for (int j = 0; j < 7; j++) begin
            cycle(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            check_eq("drain_addr", ex_inst_addr, 32'h200c + 32'(4 * j));
        end
        check_eq("drain_empty", 32'(empty), 32'd1);

        // Resolve with empty queue: no activity
        cycle(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 32'h777);
        check_eq("emptyres_type", 32'(ex_branch_type), 32'd0);
        check_eq("emptyres_flush", 32'(flush), 32'd0);
        check_eq("emptyres_empty", 32'(empty), 32'd1);
`ifdef BRQ_STATS_EN
        // 3 early resolves + 1 + 10 + 7 in the fill phase; two of them mispredicted
        check_eq("stat_resolved", stat_resolved, 32'd21);
        check_eq("stat_mispred", stat_mispred, 32'd2);
`endif

        // Reset mid-run with 3 entries outstanding and training output active
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h3000 + 32'(4 * i), 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        cycle(1'b1, 32'h300c, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("pre_rst_type", 32'(ex_branch_type), 32'd1);
        rst = 1'b0;
        #2;
        check_eq("midrst_empty", 32'(empty), 32'd1);
        check_eq("midrst_ready", 32'(enq_ready), 32'd1);
        check_eq("midrst_type", 32'(ex_branch_type), 32'd0);
`ifdef BRQ_STATS_EN
        check_eq("midrst_stat", stat_resolved, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_eq("postrst_type", 32'(ex_branch_type), 32'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
